// File: rtl/ras_ckpt.sv
// Checkpointed return address stack: circular entry array with snapshot/restore of {tos, count, top}.
// Optional RAS_STATS_EN adds saturating overflow/underflow event counters.
module ras_ckpt #(
  parameter int unsigned ADDR_W = 48,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned NCKPT  = 4,
  localparam int unsigned PW = $clog2(DEPTH),
  localparam int unsigned CW = $clog2(DEPTH + 1),
  localparam int unsigned IW = (NCKPT > 1) ? $clog2(NCKPT) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] top_data,
  output logic              top_valid,
  output logic [CW-1:0]     count,
  output logic              overflow,
  output logic              underflow,
`ifdef RAS_STATS_EN
  output logic [15:0]       ovf_events,
  output logic [15:0]       unf_events,
`endif
  input  logic              ckpt_save,
  input  logic [IW-1:0]     ckpt_save_idx,
  input  logic              ckpt_restore,
  input  logic [IW-1:0]     ckpt_restore_idx
);

  logic [ADDR_W-1:0] stk [DEPTH];
  logic [PW-1:0]     tos_q, tos_d;
  logic [CW-1:0]     count_q, count_d;
  logic              ovf_q, ovf_d, unf_q, unf_d;

  logic [PW-1:0]     ck_tos_q [NCKPT];
  logic [CW-1:0]     ck_cnt_q [NCKPT];
  logic [ADDR_W-1:0] ck_top_q [NCKPT];

  logic              wr_en;
  logic [PW-1:0]     wr_idx;
  logic [ADDR_W-1:0] wr_data;
  logic [ADDR_W-1:0] save_top;

  always_comb begin
    tos_d   = tos_q;
    count_d = count_q;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    wr_en   = 1'b0;
    wr_idx  = tos_q;
    wr_data = push_data;
    if (ckpt_restore) begin
      // Rewrite the saved top so a wrong-path replace/push over it is undone.
      tos_d   = ck_tos_q[ckpt_restore_idx];
      count_d = ck_cnt_q[ckpt_restore_idx];
      wr_en   = 1'b1;
      wr_idx  = ck_tos_q[ckpt_restore_idx];
      wr_data = ck_top_q[ckpt_restore_idx];
    end else if (push && pop && (count_q != '0)) begin
      wr_en = 1'b1;
    end else if (push) begin
      tos_d  = tos_q + 1'b1;
      wr_en  = 1'b1;
      wr_idx = tos_q + 1'b1;
      if (count_q == CW'(DEPTH)) begin
        ovf_d = 1'b1;
      end else begin
        count_d = count_q + 1'b1;
      end
    end else if (pop) begin
      if (count_q != '0) begin
        tos_d   = tos_q - 1'b1;
        count_d = count_q - 1'b1;
      end else begin
        unf_d = 1'b1;
      end
    end
  end

  // Every write lands on tos_d, so the post-update top is the write data when writing.
  assign save_top = wr_en ? wr_data : stk[tos_d];

  always_ff @(posedge clk) begin
    if (wr_en && !reset) begin
      stk[wr_idx] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tos_q   <= PW'(DEPTH - 1);
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      tos_q   <= tos_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(NCKPT); i++) begin
        ck_tos_q[i] <= PW'(DEPTH - 1);
        ck_cnt_q[i] <= '0;
        ck_top_q[i] <= '0;
      end
    end else if (ckpt_save) begin
      ck_tos_q[ckpt_save_idx] <= tos_d;
      ck_cnt_q[ckpt_save_idx] <= count_d;
      ck_top_q[ckpt_save_idx] <= save_top;
    end
  end

  assign top_valid = (count_q != '0);
  assign top_data  = top_valid ? stk[tos_q] : '0;
  assign count     = count_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

`ifdef RAS_STATS_EN
  logic [15:0] ovf_cnt_q, unf_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_cnt_q <= '0;
      unf_cnt_q <= '0;
    end else begin
      if (ovf_d && (ovf_cnt_q != 16'hFFFF)) ovf_cnt_q <= ovf_cnt_q + 16'd1;
      if (unf_d && (unf_cnt_q != 16'hFFFF)) unf_cnt_q <= unf_cnt_q + 16'd1;
    end
  end

  assign ovf_events = ovf_cnt_q;
  assign unf_events = unf_cnt_q;
`endif

endmodule

// File: tb/tb_ras_ckpt.sv
// Self-checking bench for ras_ckpt: directed test-plan steps plus random traffic
// compared against a behavioural stack/checkpoint model.
module tb_ras_ckpt;
  localparam int AW = 32;
  localparam int D  = 4;
  localparam int NC = 4;
  localparam int CW = $clog2(D + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, push, pop, ckpt_save, ckpt_restore;
  logic [AW-1:0] push_data;
  logic [1:0]    ckpt_save_idx, ckpt_restore_idx;
  logic [AW-1:0] top_data;
  logic          top_valid, overflow, underflow;
  logic [CW-1:0] count;
`ifdef RAS_STATS_EN
  logic [15:0]   ovf_events, unf_events;
`endif

  ras_ckpt #(.ADDR_W(AW), .DEPTH(D), .NCKPT(NC)) dut (
    .clk              (clk),
    .reset            (reset),
    .push             (push),
    .pop              (pop),
    .push_data        (push_data),
    .top_data         (top_data),
    .top_valid        (top_valid),
    .count            (count),
    .overflow         (overflow),
    .underflow        (underflow),
`ifdef RAS_STATS_EN
    .ovf_events       (ovf_events),
    .unf_events       (unf_events),
`endif
    .ckpt_save        (ckpt_save),
    .ckpt_save_idx    (ckpt_save_idx),
    .ckpt_restore     (ckpt_restore),
    .ckpt_restore_idx (ckpt_restore_idx)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [AW-1:0] m_stk [D];
  int            m_tos, m_cnt;
  bit            m_ovf, m_unf;
  int            m_ctos [NC];
  int            m_ccnt [NC];
  logic [AW-1:0] m_ctop [NC];
  int            m_ovfev, m_unfev;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    if (reset) begin
      m_tos = D - 1; m_cnt = 0; m_ovf = 0; m_unf = 0; m_ovfev = 0; m_unfev = 0;
      for (int i = 0; i < NC; i++) begin
        m_ctos[i] = D - 1; m_ccnt[i] = 0; m_ctop[i] = '0;
      end
      return;
    end
    m_ovf = 0;
    m_unf = 0;
    if (ckpt_restore) begin
      m_tos = m_ctos[ckpt_restore_idx];
      m_cnt = m_ccnt[ckpt_restore_idx];
      m_stk[m_tos] = m_ctop[ckpt_restore_idx];
    end else if (push && pop && m_cnt > 0) begin
      m_stk[m_tos] = push_data;
    end else if (push) begin
      m_ovf = (m_cnt == D);
      m_tos = (m_tos + 1) % D;
      m_stk[m_tos] = push_data;
      m_cnt = (m_cnt + 1 > D) ? D : m_cnt + 1;
    end else if (pop) begin
      if (m_cnt > 0) begin
        m_tos = (m_tos + D - 1) % D;
        m_cnt--;
      end else begin
        m_unf = 1;
      end
    end
    if (ckpt_save) begin
      m_ctos[ckpt_save_idx] = m_tos;
      m_ccnt[ckpt_save_idx] = m_cnt;
      m_ctop[ckpt_save_idx] = m_stk[m_tos];
    end
    if (m_ovf && m_ovfev < 65535) m_ovfev++;
    if (m_unf && m_unfev < 65535) m_unfev++;
  endtask

  task automatic compare_all();
    check("count", 64'(count), 64'(m_cnt));
    check("top_valid", 64'(top_valid), 64'(m_cnt != 0));
    check("top_data", 64'(top_data), (m_cnt != 0) ? 64'(m_stk[m_tos]) : 64'd0);
    check("overflow", 64'(overflow), 64'(m_ovf));
    check("underflow", 64'(underflow), 64'(m_unf));
`ifdef RAS_STATS_EN
    check("ovf_events", 64'(ovf_events), 64'(m_ovfev));
    check("unf_events", 64'(unf_events), 64'(m_unfev));
`endif
  endtask

  task automatic step(input bit rst, input bit ps, input bit pp, input logic [AW-1:0] d,
                      input bit sv, input int si, input bit rr, input int ri);
    reset = rst; push = ps; pop = pp; push_data = d;
    ckpt_save = sv; ckpt_save_idx = 2'(si);
    ckpt_restore = rr; ckpt_restore_idx = 2'(ri);
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    step(1, 0, 0, '0, 0, 0, 0, 0);
  endtask

  task automatic do_push(input logic [AW-1:0] d);
    step(0, 1, 0, d, 0, 0, 0, 0);
  endtask

  task automatic do_pop();
    step(0, 0, 1, '0, 0, 0, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < D; i++) m_stk[i] = '0;
    do_reset();
    check("reset_count", 64'(count), 64'd0);
    check("reset_valid", 64'(top_valid), 64'd0);

    // Basic push/pop
    do_push(32'hA1); do_push(32'hA2); do_push(32'hA3);
    check("p3_count", 64'(count), 64'd3);
    check("p3_top", 64'(top_data), 64'hA3);
    do_pop();
    check("pop_top", 64'(top_data), 64'hA2);
    check("pop_count", 64'(count), 64'd2);

    // Overflow wrap at DEPTH=4
    do_reset();
    do_push(32'h10); do_push(32'h20); do_push(32'h30); do_push(32'h40);
    check("no_ovf_yet", 64'(overflow), 64'd0);
    do_push(32'h50);
    check("ovf_pulse", 64'(overflow), 64'd1);
    check("ovf_count", 64'(count), 64'd4);
    check("ovf_top", 64'(top_data), 64'h50);
    do_pop();
    check("ovf_pulse_end", 64'(overflow), 64'd0);
    check("wrap_pop1", 64'(top_data), 64'h40);
    do_pop();
    check("wrap_pop2", 64'(top_data), 64'h30);
    do_pop();
    check("wrap_pop3", 64'(top_data), 64'h20);
    do_pop();
    check("wrap_empty", 64'(top_valid), 64'd0);

    // Underflow
    do_pop();
    check("unf_pulse", 64'(underflow), 64'd1);
    check("unf_count", 64'(count), 64'd0);
    check("unf_top", 64'(top_data), 64'd0);
    do_push(32'h99);
    check("unf_pulse_end", 64'(underflow), 64'd0);
    check("after_unf_top", 64'(top_data), 64'h99);

    // Replace
    do_reset();
    do_push(32'h100);
    step(0, 1, 1, 32'h200, 0, 0, 0, 0);
    check("repl_count", 64'(count), 64'd1);
    check("repl_top", 64'(top_data), 64'h200);
    do_reset();
    step(0, 1, 1, 32'h300, 0, 0, 0, 0);
    check("repl_empty_count", 64'(count), 64'd1);
    check("repl_empty_top", 64'(top_data), 64'h300);

    // Checkpoint repair
    do_reset();
    do_push(32'hA0);
    step(0, 1, 0, 32'hB0, 1, 2, 0, 0);
    do_pop();
    do_push(32'hC0);
    check("wrong_path_top", 64'(top_data), 64'hC0);
    step(0, 0, 0, '0, 0, 0, 1, 2);
    check("rst_count", 64'(count), 64'd2);
    check("rst_top", 64'(top_data), 64'hB0);
    do_pop();
    check("rst_pop_top", 64'(top_data), 64'hA0);

    // Reset overrides push+save; restored slot is empty
    do_push(32'hD0);
    step(1, 1, 0, 32'hE0, 1, 1, 0, 0);
    check("mid_reset_count", 64'(count), 64'd0);
    step(0, 0, 0, '0, 0, 0, 1, 1);
    check("restore_cleared", 64'(count), 64'd0);
    check("restore_cleared_v", 64'(top_valid), 64'd0);

    do_pop(); do_pop(); do_pop();
`ifdef RAS_STATS_EN
    check("unf_events3", 64'(unf_events), 64'd3);
`endif

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 59) == 0), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
           $urandom, $urandom_range(0, 3) == 0, int'($urandom_range(0, NC - 1)),
           $urandom_range(0, 5) == 0, int'($urandom_range(0, NC - 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ras_ckpt.md
# ras_ckpt

Checkpointed return address stack for the stage-1 fetch predictor, parametrised in address width, depth and number of recovery checkpoints. It predicts return targets: calls push, returns pop, and a call and return in the same cycle replace the top entry. The difference from a plain stack is speculative repair. Fetch snapshots the stack state on predicted branches, and the back end restores a snapshot on misprediction, so wrong-path calls and returns do not corrupt the stack. Overflow wraps circularly, overwriting the oldest entry. Underflow is detected and flagged.

## Interface
- `ADDR_W`, 48, return-address width in bits.
- `DEPTH`, 8, number of stack entries; power of 2, ≥2.
- `NCKPT`, 4, number of checkpoint slots; ≥1.
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `push`  in  1  push `push_data` (call).
- `pop`  in  1  pop top entry (return).
- `push_data`  in  ADDR_W  return address to push or replace.
- `top_data`  out  ADDR_W  current top-of-stack prediction.
- `top_valid`  out  1  stack non-empty.
- `count`  out  $clog2(DEPTH+1)  number of valid entries.
- `overflow`  out  1  registered 1-cycle pulse: last push overwrote the oldest entry.
- `underflow`  out  1  registered 1-cycle pulse: last pop hit an empty stack.
- `ckpt_save`  in  1  capture snapshot into slot `ckpt_save_idx`.
- `ckpt_save_idx`  in  $clog2(NCKPT) (min 1)  save slot.
- `ckpt_restore`  in  1  restore snapshot from slot `ckpt_restore_idx`.
- `ckpt_restore_idx`  in  $clog2(NCKPT) (min 1)  restore slot.

## Operation
- State:
  - entry array `stk[DEPTH]`, not reset;
  - `tos` pointer, $clog2(DEPTH) bits;
  - `count`;
  - checkpoint slots, each holding {tos, count, top entry value}.
- Reset sets:
  - `tos` = DEPTH-1;
  - `count` = 0;
  - `overflow` = 0, `underflow` = 0;
  - all checkpoint slots = {DEPTH-1, 0, 0}.
- `top_data` = `stk[tos]` when `count` != 0, else 0. `top_valid` = (`count` != 0).
- Priority per cycle: `ckpt_restore` > stack operation. While a restore is active, push and pop are ignored.
- Push only:
  - `tos` ← `tos`+1 mod DEPTH;
  - `stk[tos+1]` ← `push_data`;
  - `count` ← min(`count`+1, DEPTH);
  - `overflow` pulses if `count` was DEPTH; the oldest entry is lost and the wrap is silent otherwise.
- Pop only:
  - if `count` > 0: `tos` ← `tos`-1 mod DEPTH and `count` ← `count`-1. Entry data is untouched.
  - if `count` = 0: no state change, and `underflow` pulses.
- Push and pop together (replace):
  - if `count` > 0: `stk[tos]` ← `push_data`; pointer and count unchanged.
  - if `count` = 0: behaves as push only.
- Restore from slot k:
  - `tos` ← k.tos, `count` ← k.count;
  - `stk[k.tos]` ← k.top, repairing a top entry overwritten on the wrong path.
  - Restoring a never-written slot yields the reset state.
- Save into slot k captures the state as it will be after this cycle's update: post-push, post-pop, or post-restore. The captured top value is the next-cycle `stk[tos]`, including same-cycle `push_data`.
- Save and restore in the same cycle, same slot: the slot receives the restored state.
- Deeper entries overwritten on the wrong path are not repaired. This is an accepted loss of prediction accuracy.

## Timing
- All updates take effect at the rising edge. `top_data`, `top_valid` and `count` are combinational from registered state, so they reflect an operation one cycle later.
- No same-cycle bypass: `top_data` does not show `push_data` in the cycle it is pushed.
- `overflow` and `underflow` assert in the cycle after the causing operation, for exactly 1 cycle.
- Reset asserted mid-sequence: reset state next cycle regardless of push, pop or ckpt inputs. Checkpoints are cleared as well.
- No handshake: every request is accepted every cycle.

## Configuration
- `RAS_STATS_EN` defined:
  - adds output ports `ovf_events` and `unf_events`, each 16 bits;
  - each increments once per `overflow`/`underflow` pulse, saturates at 16'hFFFF, and is cleared by `reset`.
- `RAS_STATS_EN` undefined: these ports and counters are absent, and all other behaviour is identical.

## Test plan
- After reset, push A1, A2, A3 (DEPTH=8) -> `count`=3, `top_data`=A3. Pop -> `top_data`=A2, `count`=2.
- DEPTH=4: push 0x10, 0x20, 0x30, 0x40, 0x50 -> `overflow` pulses once, after the 5th push; `count`=4. Four pops return 0x50, 0x40, 0x30, 0x20, then `top_valid`=0.
- Pop on empty stack -> `underflow`=1 for one cycle; `count` stays 0 and `top_data`=0. Push 0x99 -> `top_data`=0x99.
- Push 0x100, then push+pop with 0x200 -> `count`=1, `top_data`=0x200. Push+pop on empty stack with 0x300 -> `count`=1, `top_data`=0x300.
- Push 0xA0, 0xB0, save slot 2; then pop, push 0xC0 (overwrites the 0xB0 location). Restore slot 2 -> `count`=2, `top_data`=0xB0; a following pop gives `top_data`=0xA0.
- Reset asserted during a push+save cycle -> next cycle `count`=0; restoring that slot gives the empty state. With `RAS_STATS_EN`: 3 underflows -> `unf_events`=3.
